// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core: one FSM, one shared ALU, one unified memory port (req/ready).
// Optional PERF_CNT_EN macro adds cycle_cnt/instr_cnt performance counter outputs.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  TEST_REG = 5'd8,
    parameter int unsigned TEST_W   = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [TEST_W-1:0] test_value
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
        StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StHalt
    } state_e;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    state_e      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
    logic [31:0] regs_q [32];
    logic        halted_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

    // Shared ALU: operand and operation selection depends on the current state
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_e     alu_op;

    always_comb begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = AluAdd;
        case (state_q)
            StFetch: begin
                alu_a = pc_q;
                alu_b = 32'd4;
            end
            StDecode: begin
                alu_a = pc_q;
                alu_b = {simm[29:0], 2'b00};
            end
            StMemAdr, StAddiEx: alu_b = simm;
            StExec: begin
                case (funct)
                    6'h22:   alu_op = AluSub;
                    6'h24:   alu_op = AluAnd;
                    6'h25:   alu_op = AluOr;
                    6'h2A:   alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            AluSub:  alu_y = alu_a - alu_b;
            AluAnd:  alu_y = alu_a & alu_b;
            AluOr:   alu_y = alu_a | alu_b;
            AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Memory port; gated by Reset so an in-flight access cannot complete during reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        if (!Reset) begin
            case (state_q)
                StFetch: mem_req = 1'b1;
                StMemRd: begin
                    mem_req  = 1'b1;
                    mem_addr = alu_out_q;
                end
                StMemWr: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = alu_out_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            halted_q  <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= alu_y;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    a_q       <= regs_q[rs];
                    b_q       <= regs_q[rt];
                    alu_out_q <= alu_y;
                    case (opcode)
                        OpRtype:    state_q <= StExec;
                        OpLw, OpSw: state_q <= StMemAdr;
                        OpBeq:      state_q <= StBranch;
                        OpAddi:     state_q <= StAddiEx;
                        OpJ:        state_q <= StJump;
                        default: begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                StMemAdr: begin
                    alu_out_q <= alu_y;
                    state_q   <= (opcode == OpLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        state_q <= StMemWb;
                    end
                end
                StMemWb: begin
                    if (rt != 5'd0) regs_q[rt] <= mdr_q;
                    state_q <= StFetch;
                end
                StMemWr: begin
                    if (mem_ready) state_q <= StFetch;
                end
                StExec: begin
                    alu_out_q <= alu_y;
                    state_q   <= StAluWb;
                end
                StAluWb: begin
                    if (rd != 5'd0) regs_q[rd] <= alu_out_q;
                    state_q <= StFetch;
                end
                StAddiEx: begin
                    alu_out_q <= alu_y;
                    state_q   <= StAddiWb;
                end
                StAddiWb: begin
                    if (rt != 5'd0) regs_q[rt] <= alu_out_q;
                    state_q <= StFetch;
                end
                StBranch: begin
                    if (a_q == b_q) pc_q <= alu_out_q;
                    state_q <= StFetch;
                end
                StJump: begin
                    pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_q <= StFetch;
                end
                default: state_q <= StHalt;
            endcase
        end
    end

    assign halted     = halted_q;
    assign test_value = regs_q[TEST_REG][TEST_W-1:0];

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, instr_q;
    logic        instr_done;

    // Every path that returns to fetch marks one retired instruction
    always_comb begin
        instr_done = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StAddiWb) ||
                     (state_q == StBranch) || (state_q == StJump) ||
                     ((state_q == StMemWr) && mem_ready);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else if (state_q != StHalt) begin
            cycle_q <= cycle_q + 32'd1;
            if (instr_done) instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule
